// File: rtl/memwb_stage_buf.sv
// ============================================================================
// Module  : memwb_stage_buf
// Brief   : Elastic two-entry (main + skid) MEM/WB buffer with flush and a
//           forwarding tap. Optional counters under MEMWB_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memwb_stage_buf #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    input  logic [DW-1:0] data_mem_in,
    input  logic [DW-1:0] aluResIn,
    input  logic [RW-1:0] writeRegIn,
    input  logic          MemToRegIn,
    input  logic          RegWriteIn,
    input  logic          MemReadIn,
    input  logic          writeRegValidIn,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] data_mem_out,
    output logic [DW-1:0] aluResOut,
    output logic [RW-1:0] writeRegOut,
    output logic          MemToRegOut,
    output logic          RegWriteOut,
    output logic          MemReadOut,
    output logic          writeRegValidOut,
    output logic          fwd_valid,
`ifdef MEMWB_PERF_CNT_EN
    output logic [31:0]   stall_cnt,
    output logic [7:0]    flush_drop_cnt,
`endif
    output logic [DW-1:0] fwd_value
);

    // Payload layout: {data_mem, alu, wreg, MemToReg, RegWrite, MemRead, wregValid}
    localparam int PW = 2*DW + RW + 4;

    logic [PW-1:0] main_pl_q, main_pl_d;
    logic [PW-1:0] skid_pl_q, skid_pl_d;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [PW-1:0] w_in_pl;
    logic          w_accept;
    logic          w_pop;
    logic          w_main_free;

    assign w_in_pl     = {data_mem_in, aluResIn, writeRegIn,
                          MemToRegIn, RegWriteIn, MemReadIn, writeRegValidIn};
    assign w_accept    = in_valid & in_ready_q;
    assign w_pop       = main_valid_q & out_ready;
    assign w_main_free = ~main_valid_q | w_pop;

    always_comb begin
        main_pl_d    = main_pl_q;
        skid_pl_d    = skid_pl_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Payload is left stale; only the valid bits matter after a kill.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_main_free) begin
            if (skid_valid_q) begin
                main_pl_d    = skid_pl_q;
                main_valid_d = 1'b1;
                skid_valid_d = w_accept;
                if (w_accept) begin
                    skid_pl_d = w_in_pl;
                end
            end else begin
                main_valid_d = w_accept;
                if (w_accept) begin
                    main_pl_d = w_in_pl;
                end
            end
        end else if (w_accept) begin
            skid_pl_d    = w_in_pl;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_pl_q    <= '0;
            skid_pl_q    <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_pl_q    <= main_pl_d;
            skid_pl_q    <= skid_pl_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = main_valid_q;
    assign data_mem_out     = main_pl_q[PW-1 -: DW];
    assign aluResOut        = main_pl_q[PW-DW-1 -: DW];
    assign writeRegOut      = main_pl_q[4 +: RW];
    assign MemToRegOut      = main_pl_q[3];
    assign RegWriteOut      = main_pl_q[2] & main_valid_q;
    assign MemReadOut       = main_pl_q[1];
    assign writeRegValidOut = main_pl_q[0];
    assign fwd_valid        = main_valid_q & RegWriteOut & writeRegValidOut;
    assign fwd_value        = MemToRegOut ? data_mem_out : aluResOut;

`ifdef MEMWB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  flush_drop_cnt_q, flush_drop_cnt_d;
    logic [1:0]  w_drop_n;
    logic [8:0]  w_drop_sum;

    // A beat popped on the flush edge was consumed, so it is not a drop.
    assign w_drop_n   = {1'b0, main_valid_q & ~w_pop} + {1'b0, skid_valid_q};
    assign w_drop_sum = {1'b0, flush_drop_cnt_q} + {7'b0, w_drop_n};

    always_comb begin
        stall_cnt_d      = stall_cnt_q;
        flush_drop_cnt_d = flush_drop_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush) begin
            flush_drop_cnt_d = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q      <= '0;
            flush_drop_cnt_q <= '0;
        end else begin
            stall_cnt_q      <= stall_cnt_d;
            flush_drop_cnt_q <= flush_drop_cnt_d;
        end
    end

    assign stall_cnt      = stall_cnt_q;
    assign flush_drop_cnt = flush_drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memwb_stage_buf.sv
// Testbench for memwb_stage_buf: directed steps followed by a randomized run,
// all compared against a queue-based model of the two-entry buffer.
`default_nettype none

module tb_memwb_stage_buf;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic [DW-1:0] dm;
        logic [DW-1:0] alu;
        logic [RW-1:0] wr;
        logic          m2r;
        logic          rw;
        logic          mr;
        logic          wrv;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    beat_t         in_b = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] data_mem_out, aluResOut, fwd_value;
    logic [RW-1:0] writeRegOut;
    logic          MemToRegOut, RegWriteOut, MemReadOut, writeRegValidOut, fwd_valid;
`ifdef MEMWB_PERF_CNT_EN
    logic [31:0]   stall_cnt;
    logic [7:0]    flush_drop_cnt;
`endif

    memwb_stage_buf #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .data_mem_in(in_b.dm), .aluResIn(in_b.alu),
        .writeRegIn(in_b.wr), .MemToRegIn(in_b.m2r), .RegWriteIn(in_b.rw),
        .MemReadIn(in_b.mr), .writeRegValidIn(in_b.wrv),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_mem_out(data_mem_out), .aluResOut(aluResOut),
        .writeRegOut(writeRegOut), .MemToRegOut(MemToRegOut),
        .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut),
        .writeRegValidOut(writeRegValidOut), .fwd_valid(fwd_valid),
`ifdef MEMWB_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_drop_cnt(flush_drop_cnt),
`endif
        .fwd_value(fwd_value)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_fail   = 0;
    beat_t  m_q[$];
    longint m_stall = 0;
    int     m_drop  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a FIFO of at most two beats; ready whenever fewer than two are held.
    task automatic tick();
        bit acc, pop;
        int sz;
        @(posedge clk);
        sz  = m_q.size();
        acc = in_valid && (sz < 2);
        pop = (sz > 0) && out_ready;
        if (sz > 0 && !out_ready) m_stall++;
        if (flush) begin
            m_drop = m_drop + sz - (pop ? 1 : 0);
            if (m_drop > 255) m_drop = 255;
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(in_b);
        end
        #2;
    endtask

    task automatic check_model(input string tag);
        beat_t h;
        logic  r;
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(m_q.size() > 0));
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(m_q.size() < 2));
        if (m_q.size() > 0) begin
            h = m_q[0];
            chk({tag, ".payload"},
                128'({data_mem_out, aluResOut, writeRegOut, MemToRegOut,
                      RegWriteOut, MemReadOut, writeRegValidOut}), 128'(h));
            chk({tag, ".fwd_valid"}, 128'(fwd_valid), 128'(h.rw & h.wrv));
            chk({tag, ".fwd_value"}, 128'(fwd_value), 128'(h.m2r ? h.dm : h.alu));
        end else begin
            chk({tag, ".regwrite_idle"}, 128'(RegWriteOut), 128'(0));
            chk({tag, ".fwd_valid_idle"}, 128'(fwd_valid), 128'(0));
        end
`ifdef MEMWB_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
        chk({tag, ".flush_drop_cnt"}, 128'(flush_drop_cnt), 128'(m_drop));
`endif
        r = in_ready;
        out_ready = ~out_ready;
        #1;
        chk({tag, ".in_ready_comb"}, 128'(in_ready), 128'(r));
        out_ready = ~out_ready;
        #1;
    endtask

    function automatic beat_t mk(input logic [DW-1:0] dm, input logic [DW-1:0] alu,
                                 input logic [RW-1:0] wr, input logic m2r,
                                 input logic rw, input logic wrv);
        beat_t b;
        b.dm = dm; b.alu = alu; b.wr = wr; b.m2r = m2r; b.rw = rw; b.mr = m2r; b.wrv = wrv;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.dm = $urandom; b.alu = $urandom; b.wr = RW'($urandom);
        b.m2r = 1'($urandom); b.rw = 1'($urandom); b.mr = 1'($urandom); b.wrv = 1'($urandom);
        return b;
    endfunction

    initial begin
        int drop0;
        // Reset state
        #12;
        chk("rst.out_valid", 128'(out_valid), 128'(0));
        chk("rst.in_ready", 128'(in_ready), 128'(1));
        chk("rst.fwd_value", 128'(fwd_value), 128'(0));
        chk("rst.regwrite", 128'(RegWriteOut), 128'(0));
        rst = 1'b1;

        // Single beat with forwarding of the ALU result
        in_b = mk(0, 32'h1234, 5, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single.fwd_value", 128'(fwd_value), 128'(32'h1234));
        chk("single.fwd_valid", 128'(fwd_valid), 128'(1));
        chk("single.wreg", 128'(writeRegOut), 128'(5));
        check_model("single");
        tick();
        check_model("single_drain");

        // Back-pressure: two beats fill main and skid
        out_ready = 1'b0;
        in_b = mk(0, 32'h0001, 1, 1'b0, 1'b1, 1'b1); in_valid = 1'b1;
        tick(); check_model("bp_a");
        in_b = mk(0, 32'h0002, 2, 1'b0, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp.in_ready_low", 128'(in_ready), 128'(0));
        check_model("bp_full");
        out_ready = 1'b1;
        chk("bp.head_a", 128'(aluResOut), 128'(32'h0001));
        tick();
        chk("bp.head_b", 128'(aluResOut), 128'(32'h0002));
        check_model("bp_b");
        tick();
        chk("bp.in_ready_back", 128'(in_ready), 128'(1));
        check_model("bp_done");

        // Flush with two held beats and a same-cycle input
        out_ready = 1'b0; in_valid = 1'b1;
        in_b = mk(0, 32'hD, 3, 1'b0, 1'b1, 1'b1); tick();
        in_b = mk(0, 32'hE, 4, 1'b0, 1'b1, 1'b1); tick();
        drop0 = m_drop;
        in_b = mk(0, 32'hC, 6, 1'b0, 1'b1, 1'b1); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", 128'(out_valid), 128'(0));
        chk("flush.in_ready", 128'(in_ready), 128'(1));
        chk("flush.model_drop", 128'(m_drop - drop0), 128'(2));
        check_model("flush");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_model("flush_after");
        end

        // Forward mux selects memory data; RegWrite gates fwd_valid
        in_b = mk(32'hBEEF, 32'h0F0F, 7, 1'b1, 1'b1, 1'b1); in_valid = 1'b1;
        tick();
        chk("fwd.mem_value", 128'(fwd_value), 128'(32'hBEEF));
        chk("fwd.valid", 128'(fwd_valid), 128'(1));
        check_model("fwd1");
        in_b.rw = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("fwd.noreg_valid", 128'(fwd_valid), 128'(0));
        chk("fwd.noreg_value", 128'(fwd_value), 128'(32'hBEEF));
        check_model("fwd2");
        tick();

        // Async reset with both entries full
        out_ready = 1'b0; in_valid = 1'b1;
        in_b = rnd_beat(); tick();
        in_b = rnd_beat(); tick();
        in_valid = 1'b0;
        check_model("pre_rst");
        rst = 1'b0;
        #1;
        chk("arst.out_valid", 128'(out_valid), 128'(0));
        chk("arst.regwrite", 128'(RegWriteOut), 128'(0));
        chk("arst.fwd_value", 128'(fwd_value), 128'(0));
        chk("arst.in_ready", 128'(in_ready), 128'(1));
        m_q.delete(); m_stall = 0; m_drop = 0;
        #1;
        rst = 1'b1;
        tick();
        check_model("post_rst");

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 3);
            in_b      = rnd_beat();
            tick();
            check_model("rand");
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_model("drain");
        end
        chk("drain.empty", 128'(out_valid), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
